// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide single-ported memory between the instruction-fetch
// port and the data load/store port of the MIPS core. Both ports are arbitrated round-robin.
// A fetch is carried out as four byte reads at if_addr+0..3, with the address wrapping.
//
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   if_req/if_addr                 fetch request and byte address
//   if_rdata/if_ack                assembled 32-bit instruction and a one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata      data request (d_we=1 is a store)
//   d_rdata/d_ack                  load data and a one-cycle done pulse
//   m_addr/m_wdata/m_we/m_re       memory command (registered; addr/wdata hold when idle)
//   m_rdata                        memory read data, valid MEM_LAT cycles after m_re
module mem_port_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [7:0]    d_wdata,
  output logic [7:0]    d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_wdata,
  output logic          m_we,
  output logic          m_re,
  input  logic [7:0]    m_rdata
);

  typedef enum logic [2:0] {StIdle, StIfRd, StDRd, StDWr, StWait, StDone} state_e;

  // cnt counts cycles since the grant: 0 is the first strobe cycle.
  localparam logic [2:0] Lat    = 3'(MEM_LAT);
  localparam logic [2:0] IfLast = 3'(MEM_LAT + 3);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          is_fetch_q, is_fetch_d;
  logic          last_d_q, last_d_d;    // 1: data port won the most recent grant
  logic [23:0]   buf_q, buf_d;          // fetch bytes 0..2, byte 0 ends up in [7:0]
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic [7:0]    d_rdata_q, d_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [7:0]    m_wdata_q, m_wdata_d;
  logic          m_we_q, m_we_d;
  logic          m_re_q, m_re_d;

  logic          grant_if, grant_d;
  logic [2:0]    byte_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 3'd1;
    is_fetch_d = is_fetch_q;
    last_d_d   = last_d_q;
    buf_d      = buf_q;
    if_rdata_d = if_rdata_q;
    if_ack_d   = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_ack_d    = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_we_d     = m_we_q;
    m_re_d     = m_re_q;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    byte_idx   = cnt_q - Lat;

    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        // On a conflict the port that did not win last time goes first.
        grant_d  = d_req && (!if_req || !last_d_q);
        grant_if = if_req && !grant_d;
        if (grant_if) begin
          state_d    = StIfRd;
          is_fetch_d = 1'b1;
          last_d_d   = 1'b0;
          m_re_d     = 1'b1;
          m_addr_d   = if_addr;
        end else if (grant_d) begin
          is_fetch_d = 1'b0;
          last_d_d   = 1'b1;
          m_addr_d   = d_addr;
          if (d_we) begin
            state_d   = StDWr;
            m_we_d    = 1'b1;
            m_wdata_d = d_wdata;
          end else begin
            state_d = StDRd;
            m_re_d  = 1'b1;
          end
        end
      end
      StIfRd: begin
        if (cnt_q == 3'd3) begin
          state_d = StWait;
          m_re_d  = 1'b0;
        end else begin
          m_addr_d = m_addr_q + 1'b1;  // wraps modulo 2^AW
        end
      end
      StDRd: begin
        state_d = StWait;
        m_re_d  = 1'b0;
      end
      StDWr: begin
        state_d = StDone;
        m_we_d  = 1'b0;
        d_ack_d = 1'b1;
      end
      StWait: begin
        if (is_fetch_q && cnt_q == IfLast) begin
          state_d  = StDone;
          if_ack_d = 1'b1;
        end else if (!is_fetch_q && cnt_q == Lat) begin
          state_d   = StDone;
          d_ack_d   = 1'b1;
          d_rdata_d = m_rdata;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Fetch byte k arrives MEM_LAT cycles after its strobe; the last one completes the word so
    // if_rdata only changes when a fetch finishes.
    if (is_fetch_q && (state_q == StIfRd || state_q == StWait) && cnt_q >= Lat) begin
      if (byte_idx == 3'd3) begin
        if_rdata_d = (BIG_ENDIAN != 0) ?
                     {buf_q[7:0], buf_q[15:8], buf_q[23:16], m_rdata} :
                     {m_rdata, buf_q};
      end else begin
        buf_d = {m_rdata, buf_q[23:8]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_fetch_q <= 1'b0;
      last_d_q   <= 1'b0;
      buf_q      <= '0;
      if_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_ack_q    <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_we_q     <= 1'b0;
      m_re_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_fetch_q <= is_fetch_d;
      last_d_q   <= last_d_d;
      buf_q      <= buf_d;
      if_rdata_q <= if_rdata_d;
      if_ack_q   <= if_ack_d;
      d_rdata_q  <= d_rdata_d;
      d_ack_q    <= d_ack_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_we_q     <= m_we_d;
      m_re_q     <= m_re_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_ack    = d_ack_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_we     = m_we_q;
  assign m_re     = m_re_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (MEM_LAT=1, little-endian) and
// instance B (MEM_LAT=3, big-endian), each with its own byte memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int vectors = 0;
  int miscompares = 0;

  // Instance A signals
  logic        a_if_req, a_if_ack, a_d_req, a_d_we, a_d_ack, a_m_we, a_m_re;
  logic [7:0]  a_if_addr, a_d_addr, a_d_wdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
  logic [31:0] a_if_rdata;
  // Instance B signals
  logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_m_we, b_m_re;
  logic [7:0]  b_if_addr, b_d_addr, b_d_wdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
  logic [31:0] b_if_rdata;

  mem_port_arbiter #(.AW(8), .MEM_LAT(1), .BIG_ENDIAN(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_we(a_m_we), .m_re(a_m_re), .m_rdata(a_m_rdata)
  );

  mem_port_arbiter #(.AW(8), .MEM_LAT(3), .BIG_ENDIAN(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_we(b_m_we), .m_re(b_m_re), .m_rdata(b_m_rdata)
  );

  // Memory models: read data appears MEM_LAT cycles after the strobe, 0xEE otherwise.
  logic [7:0] mem_a [256] = '{0: 8'h11, 1: 8'h22, 2: 8'h33, 3: 8'h44,
                              254: 8'hA1, 255: 8'hB2, default: 8'h00};
  logic [7:0] mem_b [256] = '{0: 8'h11, 1: 8'h22, 2: 8'h33, 3: 8'h44,
                              9: 8'h5A, default: 8'h00};
  logic [7:0] rd_a;
  logic [7:0] rd_b0, rd_b1, rd_b2;
  int wr_a = 0, re_a = 0, ovl_a = 0, ovl_b = 0, ifacks_a = 0;

  always @(posedge clk) begin
    if (a_m_we) begin
      mem_a[a_m_addr] <= a_m_wdata;
      wr_a <= wr_a + 1;
    end
    rd_a <= a_m_re ? mem_a[a_m_addr] : 8'hEE;
    if (a_m_re) re_a <= re_a + 1;
    if (a_m_re && a_m_we) ovl_a <= ovl_a + 1;
    if (a_if_ack) ifacks_a <= ifacks_a + 1;
  end
  assign a_m_rdata = rd_a;

  always @(posedge clk) begin
    if (b_m_we) mem_b[b_m_addr] <= b_m_wdata;
    rd_b0 <= b_m_re ? mem_b[b_m_addr] : 8'hEE;
    rd_b1 <= rd_b0;
    rd_b2 <= rd_b1;
    if (b_m_re && b_m_we) ovl_b <= ovl_b + 1;
  end
  assign b_m_rdata = rd_b2;

  // Order of completions on instance A: 1 = fetch, 0 = data.
  int ack_log [$];
  always @(posedge clk) begin
    if (a_if_ack) ack_log.push_back(1);
    if (a_d_ack) ack_log.push_back(0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] wrap_addr [4];
    int n0, i0, r0, k;
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst_n = 1'b0;
    {a_if_req, a_d_req, a_d_we, b_if_req, b_d_req, b_d_we} = '0;
    {a_if_addr, a_d_addr, a_d_wdata, b_if_addr, b_d_addr, b_d_wdata} = '0;
    cyc(2);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_d_rdata", {24'h0, a_d_rdata}, 0);
    chk("rst_strobes", {a_if_ack, a_d_ack, a_m_we, a_m_re}, 0);
    chk("rst_m_addr", {a_m_wdata, a_m_addr}, 0);
    rst_n = 1'b1;
    cyc(1);

    // Aligned fetch at 0
    a_if_req = 1'b1; a_if_addr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("fetch_re", a_m_re, 1);
      chk("fetch_addr", a_m_addr, i);
    end
    cyc(1);
    chk("fetch_early_ack", {a_if_ack, a_m_re}, 0);
    cyc(1);
    chk("fetch_ack", a_if_ack, 1);
    chk("fetch_rdata", a_if_rdata, 32'h44332211);
    a_if_req = 1'b0;
    cyc(1);
    chk("fetch_ack_pulse", a_if_ack, 0);
    chk("fetch_rdata_hold", a_if_rdata, 32'h44332211);

    // Store 7 to address 5
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 8'h05; a_d_wdata = 8'h07;
    cyc(1);
    chk("store_cmd", {a_m_we, a_m_re, a_m_addr, a_m_wdata}, {2'b10, 8'h05, 8'h07});
    cyc(1);
    chk("store_ack", {a_d_ack, a_m_we}, 2'b10);
    a_d_req = 1'b0;
    cyc(1);
    chk("store_once", wr_a, 1);
    chk("store_mem", {24'h0, mem_a[5]}, 32'h07);

    // Load back from address 5
    a_d_req = 1'b1; a_d_we = 1'b0;
    cyc(1);
    chk("load_cmd", {a_m_re, a_m_we, a_m_addr}, {2'b10, 8'h05});
    cyc(1);
    chk("load_early_ack", a_d_ack, 0);
    cyc(1);
    chk("load_ack", a_d_ack, 1);
    chk("load_rdata", {24'h0, a_d_rdata}, 32'h07);
    a_d_req = 1'b0;
    cyc(1);

    // Round-robin from reset with both ports requesting continuously
    rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(1);
    n0 = ack_log.size();
    a_if_req = 1'b1; a_if_addr = 8'h00;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 8'h02;
    for (int i = 0; i < 60 && ack_log.size() < n0 + 4; i++) cyc(1);
    a_if_req = 1'b0; a_d_req = 1'b0;
    chk("rr_ack_count", ack_log.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      k = (ack_log.size() > n0 + i) ? ack_log[n0 + i] : 2;
      chk("rr_order", k, (i % 2 == 0) ? 0 : 1);
    end
    chk("rr_d_rdata", {24'h0, a_d_rdata}, 32'h33);
    chk("rr_if_rdata", a_if_rdata, 32'h44332211);
    cyc(12);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(1);

    // Fetch that wraps around the top of the address space
    a_if_req = 1'b1; a_if_addr = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("wrap_addr", {a_m_re, a_m_addr}, {1'b1, wrap_addr[i]});
    end
    cyc(2);
    chk("wrap_ack", a_if_ack, 1);
    chk("wrap_rdata", a_if_rdata, 32'h2211B2A1);
    a_if_req = 1'b0;
    cyc(1);

    // Reset during fetch byte 2
    a_if_req = 1'b1; a_if_addr = 8'h00;
    cyc(3);
    chk("abort_pre_addr", {a_m_re, a_m_addr}, {1'b1, 8'h02});
    rst_n = 1'b0;
    #1;
    chk("abort_if_rdata", a_if_rdata, 0);
    chk("abort_d_rdata", {24'h0, a_d_rdata}, 0);
    chk("abort_strobes", {a_if_ack, a_d_ack, a_m_we, a_m_re, a_m_addr}, 0);
    a_if_req = 1'b0;
    i0 = ifacks_a; r0 = re_a;
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    chk("abort_no_ack", ifacks_a - i0, 0);
    chk("abort_no_replay", re_a - r0, 0);
    a_if_req = 1'b1;
    cyc(6);
    chk("refetch_ack", a_if_ack, 1);
    chk("refetch_rdata", a_if_rdata, 32'h44332211);
    a_if_req = 1'b0;
    cyc(1);

    // Instance B: MEM_LAT=3 load, then big-endian fetch
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 8'h09;
    cyc(1);
    chk("b_load_cmd", {b_m_re, b_m_we, b_m_addr}, {2'b10, 8'h09});
    cyc(3);
    chk("b_load_early_ack", b_d_ack, 0);
    cyc(1);
    chk("b_load_ack", b_d_ack, 1);
    chk("b_load_rdata", {24'h0, b_d_rdata}, 32'h5A);
    b_d_req = 1'b0;
    cyc(1);
    b_if_req = 1'b1; b_if_addr = 8'h00;
    cyc(7);
    chk("b_fetch_early_ack", b_if_ack, 0);
    cyc(1);
    chk("b_fetch_ack", b_if_ack, 1);
    chk("b_fetch_rdata", b_if_rdata, 32'h11223344);
    b_if_req = 1'b0;
    cyc(2);

    chk("a_no_overlap", ovl_a, 0);
    chk("b_no_overlap", ovl_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
